// File: rtl/mpei_uart_mon_pkg.sv
// Shared types and constants for the mpei UART receive monitor.
package mpei_uart_mon_pkg;

  localparam int OVERSAMPLE = 8;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Parity bit a correct transmitter would send for this byte.
  function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/mpei_sync_fifo.sv
// Single-clock FIFO with head-of-queue output; a push into a full FIFO is
// accepted when a pop happens in the same cycle, otherwise it is dropped.
module mpei_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              pop_s;
  logic              push_s;

  assign empty_o = (count_r == CW'(0));
  assign full_o  = (count_r == CW'(DEPTH));
  assign pop_s   = pop_i & ~empty_o;
  assign push_s  = push_i & (~full_o | pop_s);
  assign drop_o  = push_i & full_o & ~pop_s;
  assign head_o  = mem_r[rd_ptr_r];
  assign count_o = count_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_i;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mpei_uart_rx_mon.sv
// UART receive monitor: 8N1 decoder (8E1/8O1 with MPEI_UART_MON_PARITY_EN)
// with oversampled bit timing from the core's uart_scaler, feeding a FIFO.
module mpei_uart_rx_mon
  import mpei_uart_mon_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SCALER_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      uart_rxd_i,
  input  logic [SCALER_W-1:0]       uart_scaler_i,
  input  logic                      en_i,
`ifdef MPEI_UART_MON_PARITY_EN
  input  logic                      parity_en_i,
  input  logic                      parity_odd_i,
  output logic                      par_err_o,
`endif
  output logic [DATA_W-1:0]         data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      frame_err_o,
  output logic                      ovf_o,
  output logic [$clog2(DEPTH):0]    fifo_cnt_o
);

  // One bit wider than SCALER_W+3 so an all-ones scaler cannot wrap.
  localparam int TBW = SCALER_W + 4;

  logic              rx_meta_r;
  logic              rxs_r;
  logic              rxs_d_r;
  rx_state_e         state_r;
  logic [TBW-1:0]    tb_r;
  logic [TBW-1:0]    cnt_r;
  logic [2:0]        bit_idx_r;
  logic [DATA_W-1:0] shift_r;
  logic              drop_r;
  logic              push_r;
  logic              frame_err_r;
  logic              ovf_r;
  logic              fifo_drop_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic [TBW-1:0]    tb_s;
  rx_state_e         after_data_s;
`ifdef MPEI_UART_MON_PARITY_EN
  logic              par_err_r;
  assign par_err_o    = par_err_r;
  assign after_data_s = parity_en_i ? ST_PARITY : ST_STOP;
`else
  assign after_data_s = ST_STOP;
`endif

  assign tb_s = (TBW'(uart_scaler_i) + TBW'(1)) << 3;

  // Two-flop synchronizer plus one history flop for start-edge detection.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
      rxs_d_r   <= 1'b1;
    end else begin
      rx_meta_r <= uart_rxd_i;
      rxs_r     <= rx_meta_r;
      rxs_d_r   <= rxs_r;
    end
  end

  // Frame decoder FSM with bit timer, shift register and event pulses.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= ST_IDLE;
      tb_r        <= '0;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= '0;
      drop_r      <= 1'b0;
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef MPEI_UART_MON_PARITY_EN
      par_err_r   <= 1'b0;
`endif
    end else begin
      push_r      <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef MPEI_UART_MON_PARITY_EN
      par_err_r   <= 1'b0;
`endif
      if (!en_i) begin
        state_r <= ST_IDLE;
        drop_r  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (rxs_d_r && !rxs_r) begin
              tb_r    <= tb_s;
              cnt_r   <= (tb_s >> 1) - TBW'(1);
              state_r <= ST_START;
            end
          end
          ST_START: begin
            if (cnt_r == '0) begin
              if (rxs_r) begin
                state_r <= ST_IDLE;
              end else begin
                cnt_r     <= tb_r - TBW'(1);
                bit_idx_r <= 3'd0;
                drop_r    <= 1'b0;
                state_r   <= ST_DATA;
              end
            end else begin
              cnt_r <= cnt_r - TBW'(1);
            end
          end
          ST_DATA: begin
            if (cnt_r == '0) begin
              shift_r <= {rxs_r, shift_r[DATA_W-1:1]};
              cnt_r   <= tb_r - TBW'(1);
              if (bit_idx_r == 3'd7) state_r <= after_data_s;
              else                   bit_idx_r <= bit_idx_r + 3'd1;
            end else begin
              cnt_r <= cnt_r - TBW'(1);
            end
          end
          ST_PARITY: begin
`ifdef MPEI_UART_MON_PARITY_EN
            if (cnt_r == '0) begin
              if (rxs_r != calc_parity(shift_r, parity_odd_i)) begin
                par_err_r <= 1'b1;
                drop_r    <= 1'b1;
              end
              cnt_r   <= tb_r - TBW'(1);
              state_r <= ST_STOP;
            end else begin
              cnt_r <= cnt_r - TBW'(1);
            end
`else
            state_r <= ST_IDLE;
`endif
          end
          ST_STOP: begin
            if (cnt_r == '0) begin
              if (rxs_r) begin
                push_r  <= ~drop_r;
                state_r <= ST_IDLE;
              end else begin
                frame_err_r <= 1'b1;
                state_r     <= ST_BREAK;
              end
            end else begin
              cnt_r <= cnt_r - TBW'(1);
            end
          end
          ST_BREAK: begin
            if (rxs_r) state_r <= ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  // Overflow pulse is registered from the FIFO's drop indication.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ovf_r <= 1'b0;
    else         ovf_r <= fifo_drop_s;
  end

  mpei_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push_r),
    .push_data_i (shift_r),
    .pop_i       (ready_i),
    .head_o      (data_o),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .drop_o      (fifo_drop_s),
    .count_o     (fifo_cnt_o)
  );

  assign valid_o     = ~fifo_empty_s;
  assign frame_err_o = frame_err_r;
  assign ovf_o       = ovf_r;

endmodule
